// File: rtl/sd4_result_normalizer.sv
// SD4 MAC back end: signed fixed-point accumulator + shared exponent -> IEEE FP16.
// Three-stage pipeline (magnitude, leading-one normalise, RNE round/pack) under
// a single global advance enable. Subnormals flush to signed zero and overflow
// saturates to signed infinity.
module sd4_result_normalizer #(
  parameter int ACC_W  = 24,
  parameter int FRAC_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ACC_W-1:0] acc_in,
  input  logic [4:0]       exp_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_fp16,
  output logic             out_ovf,
  output logic             out_uf
);

  localparam int PW = $clog2(ACC_W);
  localparam logic [PW-1:0] TOP_IDX = PW'(ACC_W - 1);

  // The whole pipeline either advances together (bubbles included) or holds.
  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // ---------------- Stage 1: sign / magnitude ----------------
  logic             s1_valid;
  logic             s1_sign;
  logic             s1_zero;
  logic [ACC_W-1:0] s1_mag;
  logic [4:0]       s1_exp;
  logic [ACC_W-1:0] mag_d;

  // Absolute value; the most-negative input maps to 2^(ACC_W-1) as unsigned.
  always_comb begin
    mag_d = acc_in;
    if (acc_in[ACC_W-1]) mag_d = '0 - acc_in;
  end

  // Stage 1 register: captures the magnitude of the accepted input.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_zero  <= 1'b0;
      s1_mag   <= '0;
      s1_exp   <= '0;
    end else if (en) begin
      s1_valid <= in_valid;
      s1_sign  <= acc_in[ACC_W-1];
      s1_zero  <= (acc_in == '0);
      s1_mag   <= mag_d;
      s1_exp   <= exp_in;
    end
  end

  // ---------------- Stage 2: leading-one normalise ----------------
  logic             s2_valid;
  logic             s2_sign;
  logic             s2_zero;
  logic [4:0]       s2_exp;
  logic [PW-1:0]    s2_p;
  logic [9:0]       s2_man;
  logic             s2_guard;
  logic             s2_sticky;

  logic [PW-1:0]    lead_p;
  logic [ACC_W-1:0] norm;
  logic [ACC_W+11:0] ext;

  // Leading-one position, then left-align it to the MSB. Appending 12 zero
  // bits below gives the short-magnitude (p <= 10) zero padding for free.
  always_comb begin
    lead_p = '0;
    for (int unsigned i = 0; i < ACC_W; i++) begin
      if (s1_mag[i]) lead_p = PW'(i);
    end
    norm = s1_mag << (TOP_IDX - lead_p);
    ext  = {norm, 12'b0};
  end

  // Stage 2 register: mantissa, guard and sticky after dropping the hidden one.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid  <= 1'b0;
      s2_sign   <= 1'b0;
      s2_zero   <= 1'b0;
      s2_exp    <= '0;
      s2_p      <= '0;
      s2_man    <= '0;
      s2_guard  <= 1'b0;
      s2_sticky <= 1'b0;
    end else if (en) begin
      s2_valid  <= s1_valid;
      s2_sign   <= s1_sign;
      s2_zero   <= s1_zero;
      s2_exp    <= s1_exp;
      s2_p      <= lead_p;
      s2_man    <= ext[ACC_W+10:ACC_W+1];
      s2_guard  <= ext[ACC_W];
      s2_sticky <= |ext[ACC_W-1:0];
    end
  end

  // ---------------- Stage 3: round (RNE) / pack ----------------
  logic signed [9:0] e_pre;
  logic signed [9:0] e_fin;
  logic              round_up;
  logic [10:0]       man_sum;
  logic [15:0]       fp_d;
  logic              ovf_d;
  logic              uf_d;

  // Round to nearest even; range checks use the post-rounding exponent.
  always_comb begin
    e_pre    = 10'(s2_exp) + 10'(s2_p) - 10'(FRAC_W);
    round_up = s2_guard && (s2_sticky || s2_man[0]);
    man_sum  = {1'b0, s2_man} + 11'(round_up);
    e_fin    = e_pre + 10'(man_sum[10]);
    fp_d     = {s2_sign, e_fin[4:0], man_sum[9:0]};
    ovf_d    = 1'b0;
    uf_d     = 1'b0;
    if (s2_zero) begin
      fp_d = 16'h0000;
    end else if (e_fin >= 10'sd31) begin
      fp_d  = {s2_sign, 5'h1F, 10'h000};
      ovf_d = 1'b1;
    end else if (e_fin <= 10'sd0) begin
      fp_d = {s2_sign, 15'h0000};
      uf_d = 1'b1;
    end
  end

  // Output register: holds while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_fp16  <= 16'h0000;
      out_ovf   <= 1'b0;
      out_uf    <= 1'b0;
    end else if (en) begin
      out_valid <= s2_valid;
      out_fp16  <= fp_d;
      out_ovf   <= ovf_d;
      out_uf    <= uf_d;
    end
  end

endmodule

// File: tb/tb_sd4_result_normalizer.sv
// Directed bench for sd4_result_normalizer with hand-computed FP16 results.
module tb_sd4_result_normalizer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] acc_in;
  logic [4:0]  exp_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_fp16;
  logic        out_ovf;
  logic        out_uf;

  int errors = 0;
  int checks = 0;

  sd4_result_normalizer #(.ACC_W(24), .FRAC_W(10)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .acc_in   (acc_in),
    .exp_in   (exp_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_fp16 (out_fp16),
    .out_ovf  (out_ovf),
    .out_uf   (out_uf)
  );

  always #5 clk = ~clk;

  // Send one item into an empty pipeline with out_ready high and wait (bounded)
  // for its result. lat counts posedges including the accepting one; -1 on timeout.
  task automatic run_one(input logic [23:0] a, input logic [4:0] e,
                         output logic [15:0] fp, output logic ovf,
                         output logic uf, output int lat);
    @(negedge clk);
    in_valid  = 1'b1;
    acc_in    = a;
    exp_in    = e;
    out_ready = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      #1;
    end
    if (!out_valid) lat = -1;
    fp  = out_fp16;
    ovf = out_ovf;
    uf  = out_uf;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; acc_in = '0; exp_in = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (out_fp16 !== 16'h0000) begin errors++; $display("FAIL reset_out_fp16 got=%h want=0000", out_fp16); end
    checks++; if (out_ovf !== 1'b0 || out_uf !== 1'b0) begin errors++; $display("FAIL reset_flags got=%b%b want=00", out_ovf, out_uf); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
  endtask

  // Generic directed-vector runner body is repeated per task so each owns its checks.
  task automatic test_basic();
    logic [23:0] va[3] = '{24'd1024, 24'hFFF800, 24'd0};
    logic [15:0] ve[3] = '{16'h3C00, 16'hC000, 16'h0000};
    logic [15:0] fp; logic ovf, uf; int lat;
    for (int i = 0; i < 3; i++) begin
      run_one(va[i], 5'd15, fp, ovf, uf, lat);
      checks++; if (lat !== 3) begin errors++; $display("FAIL basic_latency[%0d] got=%0d want=3", i, lat); end
      checks++; if (fp !== ve[i]) begin errors++; $display("FAIL basic_fp16[%0d] got=%h want=%h", i, fp, ve[i]); end
      checks++; if (ovf !== 1'b0 || uf !== 1'b0) begin errors++; $display("FAIL basic_flags[%0d] got=%b%b want=00", i, ovf, uf); end
    end
  endtask

  task automatic test_rne();
    logic [23:0] va[3] = '{24'h001FFF, 24'h001002, 24'h001006};
    logic [15:0] ve[3] = '{16'h4800, 16'h4400, 16'h4402};
    logic [15:0] fp; logic ovf, uf; int lat;
    for (int i = 0; i < 3; i++) begin
      run_one(va[i], 5'd15, fp, ovf, uf, lat);
      checks++; if (fp !== ve[i] || ovf !== 1'b0 || uf !== 1'b0 || lat !== 3) begin
        errors++; $display("FAIL rne[%0d] got=%h ovf=%b uf=%b lat=%0d want=%h 0 0 3", i, fp, ovf, uf, lat, ve[i]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [23:0] va[2] = '{24'h7FFFFF, 24'h800000};
    logic [15:0] ve[2] = '{16'h7C00, 16'hFC00};
    logic [15:0] fp; logic ovf, uf; int lat;
    for (int i = 0; i < 2; i++) begin
      run_one(va[i], 5'd30, fp, ovf, uf, lat);
      checks++; if (fp !== ve[i] || ovf !== 1'b1 || uf !== 1'b0 || lat !== 3) begin
        errors++; $display("FAIL overflow[%0d] got=%h ovf=%b uf=%b lat=%0d want=%h 1 0 3", i, fp, ovf, uf, lat, ve[i]);
      end
    end
  endtask

  task automatic test_underflow();
    logic [23:0] va[2] = '{24'h000001, 24'hFFFFFF};
    logic [15:0] ve[2] = '{16'h0000, 16'h8000};
    logic [15:0] fp; logic ovf, uf; int lat;
    for (int i = 0; i < 2; i++) begin
      run_one(va[i], 5'd1, fp, ovf, uf, lat);
      checks++; if (fp !== ve[i] || ovf !== 1'b0 || uf !== 1'b1 || lat !== 3) begin
        errors++; $display("FAIL underflow[%0d] got=%h ovf=%b uf=%b lat=%0d want=%h 0 1 3", i, fp, ovf, uf, lat, ve[i]);
      end
    end
  endtask

  // Exponent edges: rounding carry into 31, largest finite, smallest normal, e=0.
  task automatic test_boundary();
    logic [23:0] va[4] = '{24'h001FFF, 24'h001FFF, 24'd1024, 24'd1024};
    logic [4:0]  vx[4] = '{5'd28, 5'd27, 5'd1, 5'd0};
    logic [15:0] ve[4] = '{16'h7C00, 16'h7800, 16'h0400, 16'h0000};
    logic        vo[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic        vu[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [15:0] fp; logic ovf, uf; int lat;
    for (int i = 0; i < 4; i++) begin
      run_one(va[i], vx[i], fp, ovf, uf, lat);
      checks++; if (fp !== ve[i] || ovf !== vo[i] || uf !== vu[i]) begin
        errors++; $display("FAIL boundary[%0d] got=%h ovf=%b uf=%b want=%h %b %b", i, fp, ovf, uf, ve[i], vo[i], vu[i]);
      end
    end
  endtask

  // Eight items streamed with random out_ready; checks order, stability, no loss/duplication.
  task automatic test_backpressure();
    logic [23:0] va[8] = '{24'd1024, 24'd2048, 24'd3072, 24'hFFFC00,
                           24'd512, 24'd1536, 24'hFFF400, 24'd4096};
    logic [15:0] ve[8] = '{16'h3C00, 16'h4000, 16'h4200, 16'hBC00,
                           16'h3800, 16'h3E00, 16'hC200, 16'h4400};
    int in_idx = 0;
    int out_idx = 0;
    int cyc = 0;
    logic stalled = 1'b0;
    logic [15:0] hold_fp = '0;
    while (out_idx < 8 && cyc < 400) begin
      @(negedge clk);
      out_ready = ($urandom_range(0, 1) == 1);
      in_valid  = (in_idx < 8);
      acc_in    = (in_idx < 8) ? va[in_idx] : 24'd0;
      exp_in    = 5'd15;
      #1;
      if (stalled) begin
        checks++;
        if (out_valid !== 1'b1 || out_fp16 !== hold_fp || out_ovf !== 1'b0 || out_uf !== 1'b0) begin
          errors++; $display("FAIL bp_stall_hold got=%b/%h want=1/%h", out_valid, out_fp16, hold_fp);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (out_fp16 !== ve[out_idx] || out_ovf !== 1'b0 || out_uf !== 1'b0) begin
          errors++; $display("FAIL bp_order[%0d] got=%h want=%h", out_idx, out_fp16, ve[out_idx]);
        end
        out_idx++;
      end
      stalled = out_valid && !out_ready;
      hold_fp = out_fp16;
      if (in_valid && in_ready) in_idx++;
      cyc++;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checks++; if (out_idx != 8) begin errors++; $display("FAIL bp_count got=%0d want=8", out_idx); end
    repeat (4) begin
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup got=%b want=0", out_valid); end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_midstream();
    logic [15:0] fp; logic ovf, uf; int lat;
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; exp_in = 5'd15; acc_in = 24'd1024;
    @(negedge clk); acc_in = 24'd2048;
    @(negedge clk); acc_in = 24'd3072;
    @(negedge clk); in_valid = 1'b0; rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b1 || out_fp16 !== 16'h3C00) begin
      errors++; $display("FAIL mid_inflight got=%b/%h want=1/3c00", out_valid, out_fp16);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid got=%b want=0", out_valid); end
    repeat (4) begin
      @(negedge clk);
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_discard got=%b want=0", out_valid); end
    end
    run_one(24'h001006, 5'd15, fp, ovf, uf, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL mid_after_latency got=%0d want=3", lat); end
    checks++; if (fp !== 16'h4402 || ovf !== 1'b0 || uf !== 1'b0) begin
      errors++; $display("FAIL mid_after_value got=%h ovf=%b uf=%b want=4402 0 0", fp, ovf, uf);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rne();
    test_overflow();
    test_underflow();
    test_boundary();
    test_backpressure();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
